// File: rtl/vga_fb_arbiter_pkg.sv
// Shared framebuffer definitions: default video geometry, derived word/address sizes,
// and the scanout fetch state encoding.
package vga_fb_arbiter_pkg;

  localparam int DEF_PIXEL_WIDTH  = 640;
  localparam int DEF_PIXEL_HEIGHT = 480;
  localparam int DEF_PX_PER_WORD  = 4;

  localparam int WPL = DEF_PIXEL_WIDTH / DEF_PX_PER_WORD;
  localparam int AW  = $clog2(WPL * DEF_PIXEL_HEIGHT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fb_state_e;

  function automatic int calc_wpl(input int width, input int px_per_word);
    return width / px_per_word;
  endfunction

  function automatic int calc_aw(input int width, input int px_per_word, input int height);
    return $clog2(calc_wpl(width, px_per_word) * height);
  endfunction

endpackage

// File: rtl/vga_fb_fifo.sv
// Synchronous prefetch FIFO with lookahead head, flush and occupancy count.
module vga_fb_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; stale entries are never visible because count is reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display line prefetch has priority, the CPU
// gets a forced slot after CPU_MAX_WAIT lost cycles.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter  int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter  int PIXEL_HEIGHT = DEF_PIXEL_HEIGHT,
  parameter  int PX_PER_WORD  = DEF_PX_PER_WORD,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int CPU_MAX_WAIT = 4,
  localparam int FB_WPL       = calc_wpl(PIXEL_WIDTH, PX_PER_WORD),
  localparam int FB_AW        = calc_aw(PIXEL_WIDTH, PX_PER_WORD, PIXEL_HEIGHT),
  localparam int YW           = $clog2(PIXEL_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_start,
  input  logic [YW-1:0]    line_y,
  input  logic             px_pop,
  output logic [31:0]      px_word,
  output logic             px_avail,
  output logic             underrun,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [FB_AW-1:0] cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [FB_AW-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $clog2(FB_WPL + 1);
  localparam int WW = $clog2(CPU_MAX_WAIT + 1);

  fb_state_e        state;
  logic [FB_AW-1:0] fetch_addr;
  logic [RW-1:0]    remaining;
  logic [WW-1:0]    wait_cnt;
  logic             disp_inflight;
  logic             cpu_rd_inflight;
  logic             underrun_q;
  logic [CW-1:0]    fifo_count;
  logic             fifo_avail;
  logic             fifo_push;
  logic             fifo_pop;
  logic             disp_want;
  logic             cpu_force;
  logic             cpu_grant;
  logic             disp_grant;

  // A read already in flight counts against FIFO space so a returning word always fits.
  assign disp_want  = !rst && !line_start && (state == ST_FETCH) && (remaining != '0) &&
                      ((int'(fifo_count) + int'(disp_inflight)) < FIFO_DEPTH);
  assign cpu_force  = (int'(wait_cnt) == CPU_MAX_WAIT);
  assign cpu_grant  = !rst && cpu_req && (!disp_want || cpu_force);
  assign disp_grant = disp_want && !cpu_grant;

  assign ram_en     = cpu_grant || disp_grant;
  assign ram_we     = cpu_grant && cpu_we;
  assign ram_addr   = cpu_grant ? cpu_addr : fetch_addr;
  assign ram_wdata  = cpu_wdata;
  assign cpu_gnt    = cpu_grant;
  assign cpu_rvalid = cpu_rd_inflight && !rst;
  assign cpu_rdata  = ram_rdata;

  assign fifo_avail = (fifo_count != '0) && !rst;
  assign fifo_push  = disp_inflight && !line_start;
  assign fifo_pop   = px_pop && fifo_avail;
  assign px_avail   = fifo_avail;
  assign underrun   = underrun_q;

  vga_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (line_start),
    .push  (fifo_push),
    .wdata (ram_rdata),
    .pop   (fifo_pop),
    .rdata (px_word),
    .count (fifo_count)
  );

  // NOTE: every register here uses non-blocking assignment so all terms read pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      fetch_addr      <= '0;
      remaining       <= '0;
      wait_cnt        <= '0;
      disp_inflight   <= 1'b0;
      cpu_rd_inflight <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      cpu_rd_inflight <= cpu_grant && !cpu_we;
      wait_cnt        <= (cpu_req && !cpu_grant) ? wait_cnt + 1'b1 : '0;
      if (px_pop && !fifo_avail) underrun_q <= 1'b1;

      if (line_start) begin
        state         <= ST_FETCH;
        fetch_addr    <= FB_AW'(int'(line_y) * FB_WPL);
        remaining     <= RW'(FB_WPL);
        disp_inflight <= 1'b0;
      end else begin
        disp_inflight <= disp_grant;
        if (disp_grant) begin
          fetch_addr <= fetch_addr + 1'b1;
          remaining  <= remaining - 1'b1;
        end
        if ((state == ST_FETCH) &&
            ((remaining == '0) || (disp_grant && (remaining == RW'(1))))) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized and directed bench for vga_fb_arbiter against a queue-based model of
// the line fetch, CPU arbitration and RAM contents.
module tb_vga_fb_arbiter;
  import vga_fb_arbiter_pkg::*;

  localparam int PIXEL_HEIGHT = 480;
  localparam int YW           = $clog2(PIXEL_HEIGHT);
  localparam int DEPTH        = 8;
  localparam int MAX_WAIT     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_start;
  logic [YW-1:0] line_y;
  logic          px_pop;
  logic [31:0]   px_word;
  logic          px_avail;
  logic          underrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  vga_fb_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .CPU_MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .line_y     (line_y),
    .px_pop     (px_pop),
    .px_word    (px_word),
    .px_avail   (px_avail),
    .underrun   (underrun),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_init(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // RAM with one-cycle read latency; contents seeded from ram_init
  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = ram_init(i);
  end
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    if (ram_en && ram_we)  mem[ram_addr] = ram_wdata;
  end

  // Reference model: line fetch bookkeeping and expected FIFO contents
  logic [31:0] fifo_q[$];
  bit          m_fetch, m_infl, m_under, m_rv, dwant, gexp;
  logic [31:0] m_infl_data, m_rdata;
  int          m_rem, m_next, m_wcnt;
  int          disp_issued = 0;
  int          last_disp_addr = -1;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ram_en", ram_en, 1'b0);
      check("rst_cpu_gnt", cpu_gnt, 1'b0);
      check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      check("rst_px_avail", px_avail, 1'b0);
      fifo_q.delete();
      m_fetch = 0; m_infl = 0; m_under = 0; m_rv = 0;
      m_rem = 0; m_next = 0; m_wcnt = 0;
    end else begin
      dwant = m_fetch && (m_rem > 0) && ((fifo_q.size() + int'(m_infl)) < DEPTH) && !line_start;
      gexp  = cpu_req && (!dwant || (m_wcnt == MAX_WAIT));
      check("px_avail", px_avail, fifo_q.size() != 0);
      if (fifo_q.size() != 0) check("px_word", px_word, fifo_q[0]);
      check("underrun", underrun, m_under);
      check("cpu_rvalid", cpu_rvalid, m_rv);
      if (m_rv) check("cpu_rdata", cpu_rdata, m_rdata);
      check("cpu_gnt", cpu_gnt, gexp);
      check("ram_en", ram_en, gexp || dwant);
      if (gexp) begin
        check("cpu_ram_addr", ram_addr, cpu_addr);
        check("cpu_ram_we", ram_we, cpu_we);
        if (cpu_we) check("cpu_ram_wdata", ram_wdata, cpu_wdata);
      end else if (dwant) begin
        check("disp_ram_we", ram_we, 1'b0);
        check("disp_ram_addr", ram_addr, m_next);
      end

      m_rv    = gexp && !cpu_we;
      m_rdata = mem[cpu_addr];
      m_wcnt  = (cpu_req && !gexp) ? m_wcnt + 1 : 0;
      if (px_pop && fifo_q.size() == 0) m_under = 1;

      if (line_start) begin
        fifo_q.delete();
        m_infl  = 0;
        m_next  = int'(line_y) * WPL;
        m_rem   = WPL;
        m_fetch = 1;
      end else begin
        if (px_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (m_infl) fifo_q.push_back(m_infl_data);
        m_infl = dwant && !gexp;
        if (m_infl) begin
          m_infl_data    = mem[m_next];
          last_disp_addr = m_next;
          disp_issued++;
          m_next++;
          m_rem--;
          if (m_rem == 0) m_fetch = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  base, pops, wait_n;
  bit  done, last_gnt;

  initial begin
    rst = 1'b1; line_start = 1'b0; line_y = '0; px_pop = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; last_gnt = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_underrun", underrun, 1'b0);
    check("reset_px_avail", px_avail, 1'b0);

    // CPU write then read in IDLE
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(32'h10); cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_wr_gnt", cpu_gnt, 1'b1);
    check("idle_wr_ram_we", ram_we, 1'b1);
    step(); cpu_we = 1'b0;
    @(negedge clk);
    check("idle_rd_gnt", cpu_gnt, 1'b1);
    step(); cpu_req = 1'b0;
    @(negedge clk);
    check("idle_rd_rvalid", cpu_rvalid, 1'b1);
    check("idle_rd_data", cpu_rdata, 32'hDEAD_BEEF);

    // Line 2 fills the FIFO, then one refill read per pop
    step(); line_start = 1'b1; line_y = YW'(2); base = disp_issued;
    step(); line_start = 1'b0;
    repeat (20) step();
    check("fill_reads", disp_issued - base, DEPTH);
    check("fill_last_addr", last_disp_addr, 2 * WPL + 7);
    px_pop = 1'b1; step(); px_pop = 1'b0;
    repeat (5) step();
    check("refill_reads", disp_issued - base, DEPTH + 1);
    check("refill_addr", last_disp_addr, 2 * WPL + 8);

    // New line_start while a display read is in flight
    px_pop = 1'b1; step(); px_pop = 1'b0;
    @(negedge clk);
    check("inflight_issue", ram_en, 1'b1);
    check("inflight_addr", ram_addr, 2 * WPL + 9);
    step(); line_start = 1'b1; line_y = YW'(5);
    step(); line_start = 1'b0;
    @(negedge clk);
    check("flush_empty", px_avail, 1'b0);
    check("new_line_addr", ram_addr, 5 * WPL);
    repeat (12) step();
    check("new_line_head", px_word, ram_init(5 * WPL));

    // CPU read starved by a continuously fetching display gets the forced slot
    step(); line_start = 1'b1; line_y = YW'(7);
    step(); line_start = 1'b0;
    px_pop = px_avail; step();
    px_pop = px_avail; step();
    px_pop = px_avail;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(100000);
    wait_n = 0; done = 1'b0;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin wait_n = i; done = 1'b1; end
      step();
      px_pop = px_avail;
      if (done) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    check("force_gnt_cycle", wait_n, MAX_WAIT + 1);
    @(negedge clk);
    check("force_rvalid", cpu_rvalid, 1'b1);
    check("force_rdata", cpu_rdata, ram_init(100000));
    step(); px_pop = 1'b0;

    // Full last line fetched and drained
    step(); line_start = 1'b1; line_y = YW'(PIXEL_HEIGHT - 1); base = disp_issued;
    step(); line_start = 1'b0; pops = 0;
    for (int i = 0; i < 3000 && pops < WPL; i++) begin
      px_pop = px_avail;
      if (px_avail) pops++;
      step();
    end
    px_pop = 1'b0;
    check("line_words", disp_issued - base, WPL);
    check("line_pops", pops, WPL);
    check("line_last_addr", last_disp_addr, WPL * PIXEL_HEIGHT - 1);
    base = disp_issued;
    repeat (10) step();
    check("idle_no_reads", disp_issued - base, 0);
    check("idle_empty", px_avail, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      line_start = ($urandom_range(0, 199) == 0);
      line_y     = YW'($urandom_range(0, PIXEL_HEIGHT - 1));
      px_pop     = px_avail && ($urandom_range(0, 9) < 6);
      if (!cpu_req || last_gnt) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = AW'($urandom);
          cpu_wdata = $urandom;
        end else begin
          cpu_req = 1'b0;
        end
      end
      @(negedge clk);
      last_gnt = cpu_gnt;
      step();
    end
    cpu_req = 1'b0; px_pop = 1'b0; line_start = 1'b0;

    // Underrun is sticky until reset
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    check("pre_underrun", underrun, 1'b0);
    px_pop = 1'b1; step(); px_pop = 1'b0;
    @(negedge clk);
    check("underrun_set", underrun, 1'b1);
    step(); line_start = 1'b1; line_y = YW'(3);
    step(); line_start = 1'b0;
    repeat (30) begin px_pop = px_avail; step(); end
    px_pop = 1'b0;
    check("underrun_sticky", underrun, 1'b1);

    // Read outstanding at reset is dropped
    rst = 1'b1; step(); rst = 1'b0; step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(9);
    @(negedge clk);
    check("drop_rd_gnt", cpu_gnt, 1'b1);
    step(); rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("drop_rvalid_rst", cpu_rvalid, 1'b0);
    step(); rst = 1'b0; step();
    check("drop_rvalid_after", cpu_rvalid, 1'b0);
    check("underrun_cleared", underrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
